// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: MEM-stage, dbg and data-memory signals of the data memory arbiter.
// slave = arbiter view; master = requesters plus memory macro view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  en;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_stall;
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dm_cs;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;

    modport master (
        output en, mem_read, mem_write, mem_addr, mem_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dm_rdata,
        input  mem_rdata, mem_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
        input  dm_cs, dm_we, dm_addr, dm_wdata
    );

    modport slave (
        input  en, mem_read, mem_write, mem_addr, mem_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dm_rdata,
        output mem_rdata, mem_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
        output dm_cs, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data memory between MEM stage and dbg; DMEM_ARB_FAIRNESS_EN adds forced dbg grant after STARVE_MAX denials.
// Latency: reads return MEM_LAT cycles after issue, writes complete in the issue cycle.
// Backpressure: mem_stall holds the MEM stage until its access completes; dbg_req is held until dbg_gnt.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    dmem_arbiter_if.slave arb_if
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_MEM = 2'd1;
    localparam logic [1:0] ST_RD_DBG = 2'd2;
    localparam logic [2:0] LAT_LAST  = 3'(MEM_LAT);

    logic [1:0]            r_state;
    logic [2:0]            r_lat;
    logic                  r_dbg_rvalid;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;

    logic w_mem_req;
    logic w_idle;
    logic w_dbg_win;
    logic w_issue;
    logic w_dbg_gnt;
    logic w_issue_we;
    logic w_ret;
    logic w_mem_ret;
    logic w_dbg_ret;
    logic w_mem_wr_done;

    assign w_mem_req = arb_if.mem_read | arb_if.mem_write;
    assign w_idle    = (r_state == ST_IDLE);

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = (r_starve == SW'(STARVE_MAX));
    assign w_dbg_win = arb_if.dbg_req & (~w_mem_req | w_starved);

    // Every denied request cycle counts, including cycles spent waiting on a read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (w_dbg_gnt) begin
            r_starve <= '0;
        end else if (arb_if.dbg_req && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_dbg_win = arb_if.dbg_req & ~w_mem_req;
`endif

    // Gating with i_rst_n keeps the strobe and stall quiet while reset is held.
    assign w_issue    = i_rst_n & w_idle & arb_if.en & (w_mem_req | arb_if.dbg_req);
    assign w_dbg_gnt  = w_issue & w_dbg_win;
    assign w_issue_we = w_dbg_win ? arb_if.dbg_we : (~arb_if.mem_read & arb_if.mem_write);

    assign w_ret         = ~w_idle & (r_lat == LAT_LAST);
    assign w_mem_ret     = w_ret & (r_state == ST_RD_MEM);
    assign w_dbg_ret     = w_ret & (r_state == ST_RD_DBG);
    assign w_mem_wr_done = w_issue & ~w_dbg_win & ~arb_if.mem_read;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_lat        <= 3'd0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_dbg_rvalid <= w_dbg_ret;
            if (w_dbg_ret) begin
                r_dbg_rdata <= arb_if.dm_rdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_issue && !w_issue_we) begin
                        r_state <= w_dbg_gnt ? ST_RD_DBG : ST_RD_MEM;
                        r_lat   <= 3'd1;
                    end
                end
                ST_RD_MEM, ST_RD_DBG: begin
                    if (r_lat == LAT_LAST) begin
                        r_state <= ST_IDLE;
                        r_lat   <= 3'd0;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_lat   <= 3'd0;
                end
            endcase
        end
    end

    assign arb_if.dm_cs    = w_issue;
    assign arb_if.dm_we    = w_issue & w_issue_we;
    assign arb_if.dm_addr  = w_dbg_win ? arb_if.dbg_addr : arb_if.mem_addr;
    assign arb_if.dm_wdata = w_dbg_win ? arb_if.dbg_wdata : arb_if.mem_wdata;

    assign arb_if.mem_rdata  = w_mem_ret ? arb_if.dm_rdata : '0;
    assign arb_if.mem_stall  = i_rst_n & w_mem_req & ~(w_mem_ret | w_mem_wr_done);
    assign arb_if.dbg_gnt    = w_dbg_gnt;
    assign arb_if.dbg_rvalid = r_dbg_rvalid;
    assign arb_if.dbg_rdata  = r_dbg_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked against a cycle-timeline model.
module tb_dmem_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .arb_if (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: the memory is busy until next_issue; reads return at a known cycle number.
    int          cyc = 0;
    int          next_issue = 0;
    int          mem_ret = -1;
    int          dbg_ret = -1;
    int          starve = 0;
    logic [DW-1:0] dbg_cap = '0;

    bit          e_cs, e_we, e_stall, e_dbg_gnt, e_mem_ret, e_rvalid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_eval();
        bit mreq, idle, dwin;
        mreq      = bus.mem_read | bus.mem_write;
        idle      = (cyc >= next_issue);
        dwin      = bus.dbg_req && (!mreq || (FAIR && starve >= SMAX));
        e_cs      = rst_n && idle && bus.en && (mreq || bus.dbg_req);
        e_dbg_gnt = e_cs && dwin;
        e_we      = e_dbg_gnt ? bus.dbg_we : (!bus.mem_read && bus.mem_write);
        e_addr    = e_dbg_gnt ? bus.dbg_addr : bus.mem_addr;
        e_wdata   = e_dbg_gnt ? bus.dbg_wdata : bus.mem_wdata;
        e_mem_ret = (mem_ret == cyc);
        e_stall   = mreq && !e_mem_ret && !(e_cs && !e_dbg_gnt && !bus.mem_read);
        e_rvalid  = (dbg_ret >= 0) && (dbg_ret + 1 == cyc);
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_cs) begin
            if (e_we) begin
                next_issue = cyc + 1;
            end else begin
                next_issue = cyc + LAT + 1;
                if (e_dbg_gnt) dbg_ret = cyc + LAT;
                else           mem_ret = cyc + LAT;
            end
        end
        if (dbg_ret == cyc) dbg_cap = bus.dm_rdata;
        if (e_dbg_gnt) starve = 0;
        else if (bus.dbg_req && starve < SMAX) starve++;
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        next_issue = 0;
        mem_ret    = -1;
        dbg_ret    = -1;
        starve     = 0;
    endtask

    task automatic quiet_inputs();
        bus.en = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.dm_rdata = '0;
    endtask

    // Runs idle cycles so any outstanding model/DUT activity finishes; releases dbg on grant.
    task automatic drain(input int n);
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            model_eval();
            advance();
            if (e_dbg_gnt) bus.dbg_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        bus.mem_read = 1'b1;
        rst_n = 1'b0;
        #2;
        total++; if (bus.mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.mem_stall); end
        total++; if (bus.dm_cs !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", bus.dm_cs); end
        total++; if (bus.dbg_gnt !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL reset_dbg: got gnt=%b rvalid=%b want 0 0", bus.dbg_gnt, bus.dbg_rvalid); end
        total++; if (bus.dbg_rdata !== '0 || bus.mem_rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0", bus.dbg_rdata, bus.mem_rdata); end
        @(posedge clk); cyc++; #1;
        bus.mem_read = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_read_latency();
        drain(LAT + 2);
        bus.mem_read = 1'b1; bus.mem_addr = 32'h10; bus.dm_rdata = '0;
        for (int k = 0; k <= LAT; k++) begin
            bus.dm_rdata = (k == LAT) ? 32'hCAFE : 32'h0;
            model_eval();
            @(negedge clk);
            total++; if (bus.dm_cs !== (k == 0)) begin bad++; $display("FAIL rd_cs k=%0d: got %b want %b", k, bus.dm_cs, (k == 0)); end
            total++; if (bus.mem_stall !== (k != LAT)) begin bad++; $display("FAIL rd_stall k=%0d: got %b want %b", k, bus.mem_stall, (k != LAT)); end
            if (k == 0) begin
                total++; if (bus.dm_we !== 1'b0 || bus.dm_addr !== 32'h10) begin bad++; $display("FAIL rd_issue: got we=%b addr=%h want 0 10", bus.dm_we, bus.dm_addr); end
            end
            if (k == LAT) begin
                total++; if (bus.mem_rdata !== 32'hCAFE) begin bad++; $display("FAIL rd_data: got %h want cafe", bus.mem_rdata); end
            end
            advance();
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_write();
        drain(LAT + 2);
        bus.mem_write = 1'b1; bus.mem_addr = 32'h8; bus.mem_wdata = 32'h5;
        model_eval();
        @(negedge clk);
        total++; if (bus.dm_cs !== 1'b1 || bus.dm_we !== 1'b1) begin bad++; $display("FAIL wr_strobe: got cs=%b we=%b want 1 1", bus.dm_cs, bus.dm_we); end
        total++; if (bus.dm_addr !== 32'h8 || bus.dm_wdata !== 32'h5) begin bad++; $display("FAIL wr_bus: got %h/%h want 8/5", bus.dm_addr, bus.dm_wdata); end
        total++; if (bus.mem_stall !== 1'b0) begin bad++; $display("FAIL wr_stall: got %b want 0", bus.mem_stall); end
        advance();
        bus.mem_addr = 32'hC; bus.mem_wdata = 32'h7;
        model_eval();
        @(negedge clk);
        total++; if (bus.dm_cs !== 1'b1 || bus.dm_addr !== 32'hC || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL wr_b2b: got cs=%b addr=%h stall=%b want 1 c 0", bus.dm_cs, bus.dm_addr, bus.mem_stall); end
        advance();
        bus.mem_write = 1'b0;
    endtask

    task automatic test_starvation();
        logic [DW-1:0] ret_val;
        ret_val = '0;
        drain(LAT + 2);
        bus.mem_read = 1'b1; bus.mem_addr = 32'h30;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h40;
        for (int k = 0; k < 12; k++) begin
            bus.dm_rdata = $urandom;
            if (k == 8) ret_val = bus.dm_rdata;
            model_eval();
            @(negedge clk);
            total++; if (bus.dbg_gnt !== (FAIR && k == 6)) begin bad++; $display("FAIL starve_gnt k=%0d: got %b want %b", k, bus.dbg_gnt, (FAIR && k == 6)); end
            total++; if (bus.dbg_rvalid !== (FAIR && k == 9)) begin bad++; $display("FAIL starve_rvalid k=%0d: got %b want %b", k, bus.dbg_rvalid, (FAIR && k == 9)); end
            total++; if (bus.mem_stall !== e_stall) begin bad++; $display("FAIL starve_stall k=%0d: got %b want %b", k, bus.mem_stall, e_stall); end
            if (FAIR && k == 9) begin
                total++; if (bus.dbg_rdata !== ret_val) begin bad++; $display("FAIL starve_rdata: got %h want %h", bus.dbg_rdata, ret_val); end
            end
            advance();
            if (e_dbg_gnt) bus.dbg_req = 1'b0;
        end
        drain(2 * LAT + 4);
    endtask

    task automatic test_enable();
        drain(LAT + 2);
        bus.en = 1'b0; bus.mem_write = 1'b1; bus.mem_addr = 32'h24; bus.mem_wdata = 32'h99;
        for (int k = 0; k < 3; k++) begin
            model_eval();
            @(negedge clk);
            total++; if (bus.dm_cs !== 1'b0 || bus.mem_stall !== 1'b1) begin bad++; $display("FAIL en_hold k=%0d: got cs=%b stall=%b want 0 1", k, bus.dm_cs, bus.mem_stall); end
            advance();
        end
        bus.en = 1'b1;
        model_eval();
        @(negedge clk);
        total++; if (bus.dm_cs !== 1'b1 || bus.dm_we !== 1'b1 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL en_release: got cs=%b we=%b stall=%b want 1 1 0", bus.dm_cs, bus.dm_we, bus.mem_stall); end
        advance();
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset_midread();
        drain(LAT + 2);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
        model_eval();
        @(negedge clk);
        total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", bus.dbg_gnt); end
        advance();
        bus.dbg_req = 1'b0;
        rst_n = 1'b0; bus.mem_read = 1'b1;
        #1;
        total++; if (bus.mem_stall !== 1'b0 || bus.dm_cs !== 1'b0) begin bad++; $display("FAIL mid_stall: got stall=%b cs=%b want 0 0", bus.mem_stall, bus.dm_cs); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_rst k=%0d: got %b want 0", k, bus.dbg_rvalid); end
            @(posedge clk); cyc++; #1;
        end
        bus.mem_read = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < LAT + 2; k++) begin
            model_eval();
            @(negedge clk);
            total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid k=%0d: got %b want 0", k, bus.dbg_rvalid); end
            advance();
        end
        test_read_latency();
    endtask

    task automatic test_random();
        bit prev_stall, prev_gnt;
        prev_stall = 1'b0; prev_gnt = 1'b0;
        drain(LAT + 2);
        for (int n = 0; n < 600; n++) begin
            if (!prev_stall) begin
                case ($urandom_range(0, 3))
                    0: begin bus.mem_read = 1'b0; bus.mem_write = 1'b0; end
                    1: begin bus.mem_read = 1'b1; bus.mem_write = 1'b0; end
                    2: begin bus.mem_read = 1'b0; bus.mem_write = 1'b1; end
                    default: begin bus.mem_read = 1'b1; bus.mem_write = 1'b1; end
                endcase
                bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
            end
            if (!bus.dbg_req || prev_gnt) begin
                bus.dbg_req = ($urandom_range(0, 2) == 0);
                bus.dbg_we = $urandom_range(0, 1);
                bus.dbg_addr = $urandom; bus.dbg_wdata = $urandom;
            end
            bus.en = ($urandom_range(0, 7) != 0);
            bus.dm_rdata = $urandom;
            model_eval();
            @(negedge clk);
            total++; if (bus.dm_cs !== e_cs) begin bad++; $display("FAIL rnd_cs n=%0d: got %b want %b", n, bus.dm_cs, e_cs); end
            total++; if (bus.mem_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, bus.mem_stall, e_stall); end
            total++; if (bus.dbg_gnt !== e_dbg_gnt) begin bad++; $display("FAIL rnd_gnt n=%0d: got %b want %b", n, bus.dbg_gnt, e_dbg_gnt); end
            total++; if (bus.dbg_rvalid !== e_rvalid) begin bad++; $display("FAIL rnd_rvalid n=%0d: got %b want %b", n, bus.dbg_rvalid, e_rvalid); end
            if (e_cs) begin
                total++; if (bus.dm_we !== e_we || bus.dm_addr !== e_addr || bus.dm_wdata !== e_wdata) begin bad++; $display("FAIL rnd_bus n=%0d: got %b/%h/%h want %b/%h/%h", n, bus.dm_we, bus.dm_addr, bus.dm_wdata, e_we, e_addr, e_wdata); end
            end
            if (e_mem_ret) begin
                total++; if (bus.mem_rdata !== bus.dm_rdata) begin bad++; $display("FAIL rnd_mem_rdata n=%0d: got %h want %h", n, bus.mem_rdata, bus.dm_rdata); end
            end
            if (e_rvalid) begin
                total++; if (bus.dbg_rdata !== dbg_cap) begin bad++; $display("FAIL rnd_dbg_rdata n=%0d: got %h want %h", n, bus.dbg_rdata, dbg_cap); end
            end
            prev_stall = e_stall;
            prev_gnt   = e_dbg_gnt;
            advance();
        end
        bus.dbg_req = 1'b0;
        drain(LAT + 4);
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write();
        test_starvation();
        test_enable();
        test_reset_midread();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end
endmodule
